// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types, default sizes and slot decoding for the I2S transmitter
//   state_t  : transmitter state (IDLE until the first sample, then RUN)
//   slot_t   : decoded bit position (channel + position inside the slot)
//   slot_of  : maps a frame bit index onto channel and slot position
package i2s_pkg;
   localparam int width_def = 24;
   localparam int slot_def  = 32;
   localparam int div_def   = 4;

   typedef enum logic {IDLE, RUN} state_t;

   typedef struct packed {
      logic        right;
      int unsigned pos;
   } slot_t;

   // The first slot_width bits of a frame are the left slot, the rest the right slot.
   function automatic slot_t slot_of(input int unsigned b, input int unsigned slot);
      slot_t s;
      s.right = (b >= slot);
      s.pos   = s.right ? b - slot : b;
      return s;
   endfunction
endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: divides clk_i down to the I2S bit clock and flags its edges
//   clk_i       : system clock
//   reset_i     : asynchronous, active-low reset
//   sclk_o      : registered bit clock, 50% duty
//   rise_tick_o : high on the clk_i cycle whose edge raises sclk_o
//   fall_tick_o : high on the clk_i cycle whose edge lowers sclk_o
module i2s_clkgen
   import i2s_pkg::*;
#(
   parameter int sclk_div_p = div_def
) (
   input  logic clk_i,
   input  logic reset_i,
   output logic sclk_o,
   output logic rise_tick_o,
   output logic fall_tick_o
);
   localparam int dw = $clog2(sclk_div_p);

   logic [dw-1:0] div_r;

   assign rise_tick_o = (div_r == dw'(sclk_div_p / 2 - 1));
   assign fall_tick_o = (div_r == dw'(sclk_div_p - 1));

   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) begin
         div_r  <= '0;
         sclk_o <= 1'b0;
      end else begin
         div_r  <= fall_tick_o ? '0 : div_r + 1'b1;
         sclk_o <= rise_tick_o ? 1'b1 : fall_tick_o ? 1'b0 : sclk_o;
      end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: serialises stereo sample pairs onto an I2S link, MSB first with one-bit delay
//   clk_i      : system clock
//   reset_i    : asynchronous, active-low reset
//   left_i     : left-channel sample
//   right_i    : right-channel sample
//   valid_i    : left_i/right_i valid
//   ready_o    : holding register empty; transfer on valid_i & ready_o
//   sclk_o     : I2S bit clock
//   lrclk_o    : word select, 0 = left slot, 1 = right slot
//   sdata_o    : serial data, changes on sclk falling edges only
//   underrun_o : one-cycle pulse when a running frame starts without a sample
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int width_p      = width_def,
   parameter int slot_width_p = slot_def,
   parameter int sclk_div_p   = div_def
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] left_i,
   input  logic [width_p-1:0] right_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic               sclk_o,
   output logic               lrclk_o,
   output logic               sdata_o,
   output logic               underrun_o
);
   localparam int bw = $clog2(2 * slot_width_p);
   localparam logic [bw-1:0] last_bit = bw'(2 * slot_width_p - 1);

   logic               rise_tick, fall_tick;
   logic [bw-1:0]      bit_r, next_bit;
   logic [width_p-1:0] hold_l, hold_r, sh_l, sh_r, word;
   logic               hold_full_r, accept, boundary, next_data;
   state_t             state_r;
   slot_t              ns;

   i2s_clkgen #(.sclk_div_p(sclk_div_p)) clkgen (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .sclk_o     (sclk_o),
      .rise_tick_o(rise_tick),
      .fall_tick_o(fall_tick)
   );

   assign ready_o  = !hold_full_r;
   assign accept   = valid_i && ready_o;
   assign boundary = fall_tick && (bit_r == last_bit);
   assign next_bit = (bit_r == last_bit) ? '0 : bit_r + 1'b1;
   assign ns       = slot_of(32'(next_bit), slot_width_p);
   assign word     = ns.right ? sh_r : sh_l;
   // Position p carries bit width_p-p; p=0 is the I2S delay bit and p>width_p is padding.
   assign next_data = (ns.pos >= 1 && ns.pos <= width_p) ?
                      |(word & (width_p'(1) << (width_p - ns.pos))) : 1'b0;

   always_ff @(posedge clk_i)
      if (reset_i) assert (!(rise_tick && fall_tick));

   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) begin
         bit_r       <= last_bit;
         lrclk_o     <= 1'b1;
         sdata_o     <= 1'b0;
         underrun_o  <= 1'b0;
         hold_l      <= '0;
         hold_r      <= '0;
         hold_full_r <= 1'b0;
         sh_l        <= '0;
         sh_r        <= '0;
         state_r     <= IDLE;
      end else begin
         underrun_o <= 1'b0;
         if (accept) begin
            hold_l      <= left_i;
            hold_r      <= right_i;
            hold_full_r <= 1'b1;
         end
         if (fall_tick) begin
            bit_r   <= next_bit;
            lrclk_o <= ns.right;
            sdata_o <= next_data;
         end
         // The shadow swap is safe on the boundary itself: the bit sent there is the delay bit.
         if (boundary) begin
            if (hold_full_r) begin
               sh_l        <= hold_l;
               sh_r        <= hold_r;
               hold_full_r <= 1'b0;
               state_r     <= RUN;
            end else if (state_r == RUN) begin
               sh_l       <= '0;
               sh_r       <= '0;
               underrun_o <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized scoreboard bench for i2s_tx at default parameters
module tb_i2s_tx;
   localparam int W = 24;
   localparam int S = 32;
   localparam int D = 4;
   localparam int F = 2 * S * D;

   logic         clk = 1'b0;
   logic         reset_i = 1'b0;
   logic         valid_i = 1'b0;
   logic [W-1:0] left_i = '0;
   logic [W-1:0] right_i = '0;
   logic         ready_o, sclk_o, lrclk_o, sdata_o, underrun_o;

   i2s_tx dut (
      .clk_i     (clk),
      .reset_i   (reset_i),
      .left_i    (left_i),
      .right_i   (right_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .sclk_o    (sclk_o),
      .lrclk_o   (lrclk_o),
      .sdata_o   (sdata_o),
      .underrun_o(underrun_o)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      int           k;
      logic [W-1:0] l;
      logic [W-1:0] r;
   } smp_t;

   smp_t         q[$];
   int           total = 0, bad = 0;
   int           cyc = 0, pc = 0, last_k = 0, n = 0, nf = 0, bv = 0;
   int           mon_k = -1, idx = 0;
   bit           bnd = 0, last_bnd = 0, acc_last = 0, m_full = 0, run = 0, hit = 0;
   bit           mon_act = 0, prev_lr = 1, prev_sclk = 0, e_sclk = 0, e_und = 0;
   logic [2*S-1:0] got_d, got_lr, ed;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Expected serial stream of one frame, written first-bit-first from the MSB end.
   function automatic logic [2*S-1:0] exp_data(input logic [W-1:0] l, input logic [W-1:0] r);
      logic [2*S-1:0] e;
      logic [W-1:0]   t;
      int             p;
      e = '0;
      for (int i = 0; i < 2 * S; i++) begin
         p = i % S;
         t = ((i >= S) ? r : l) >> (W - p);
         if (p >= 1 && p <= W) e[2*S-1-i] = t[0];
      end
      return e;
   endfunction

   function automatic logic [2*S-1:0] exp_lr();
      logic [2*S-1:0] e;
      for (int i = 0; i < 2 * S; i++) e[2*S-1-i] = (i >= S);
      return e;
   endfunction

   function automatic void frame_check();
      while (q.size() > 0 && q[0].k < mon_k) begin
         chk("lost_sample_frame", 64'(q[0].k), 64'(mon_k));
         void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].k == mon_k) begin
         ed = exp_data(q[0].l, q[0].r);
         void'(q.pop_front());
      end else
         ed = exp_data('0, '0);
      chk("frame_data", got_d, ed);
      chk("frame_lrclk", got_lr, exp_lr());
   endfunction

   // Acceptance bookkeeping: frame k begins at posedge D-1+k*F after reset release.
   always @(posedge clk) begin
      if (!reset_i) begin
         cyc = 0;
         last_bnd = 0;
         acc_last = 0;
      end else begin
         pc = cyc;
         bnd = (pc >= D - 1) && ((pc - (D - 1)) % F == 0);
         acc_last = valid_i && ready_o;
         if (acc_last) q.push_back('{k: (pc < D - 1) ? 0 : (pc - (D - 1)) / F + 1, l: left_i, r: right_i});
         if (bnd && m_full) m_full = 0;
         else if (acc_last) m_full = 1;
         last_bnd = bnd;
         last_k = bnd ? (pc - (D - 1)) / F : 0;
         cyc++;
      end
   end

   // Monitor: cycle-level clock/handshake model plus frame capture on sclk rises.
   always @(negedge clk) begin
      if (!reset_i) begin
         chk("rst_sclk", 64'(sclk_o), 64'(0));
         chk("rst_lrclk", 64'(lrclk_o), 64'(1));
         chk("rst_sdata", 64'(sdata_o), 64'(0));
         chk("rst_ready", 64'(ready_o), 64'(1));
         chk("rst_underrun", 64'(underrun_o), 64'(0));
         q.delete();
         m_full = 0;
         run = 0;
         mon_k = -1;
         mon_act = 0;
         prev_lr = 1;
         prev_sclk = 0;
      end else begin
         n = cyc;
         e_sclk = (n > 0) && ((n - 1) % D >= D / 2 - 1) && ((n - 1) % D <= D - 2);
         nf = n / D;
         bv = (nf == 0) ? 2 * S - 1 : (nf - 1) % (2 * S);
         chk("sclk", 64'(sclk_o), 64'(e_sclk));
         chk("lrclk", 64'(lrclk_o), 64'(bv >= S));
         chk("ready", 64'(ready_o), 64'(!m_full));
         e_und = 0;
         if (last_bnd) begin
            hit = (q.size() > 0) && (q[0].k == last_k);
            e_und = run && !hit;
            if (hit) run = 1;
         end
         chk("underrun", 64'(underrun_o), 64'(e_und));
         if (sclk_o && !prev_sclk) begin
            if (!mon_act && prev_lr && !lrclk_o) begin
               mon_act = 1;
               idx = 0;
               mon_k++;
            end
            if (mon_act) begin
               got_d[2*S-1-idx] = sdata_o;
               got_lr[2*S-1-idx] = lrclk_o;
               idx++;
               if (idx == 2 * S) begin
                  mon_act = 0;
                  frame_check();
               end
            end
            prev_lr = lrclk_o;
         end
         prev_sclk = sclk_o;
      end
   end

   task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
      int t;
      left_i = l;
      right_i = r;
      valid_i = 1'b1;
      t = 0;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while (!acc_last && t < 4 * F);
      valid_i = 1'b0;
      chk("send_accept", 64'(acc_last), 64'(1));
   endtask

   task automatic idle(input int c);
      repeat (c) @(posedge clk);
      #1;
   endtask

   int target, t;

   initial begin
      reset_i = 1'b0;
      repeat (10) @(negedge clk);
      #1 reset_i = 1'b1;
      idle(1);
      send(24'hA5F00F, 24'h123456);
      idle(2 * F + 20);
      for (int v = 1; v <= 6; v++) send(W'(v), W'(v));
      send(24'hFFFFFF, 24'h800000);
      idle(F + 10);
      for (int i = 0; i < 8; i++) begin
         idle($urandom_range(0, 2 * F));
         send(W'($urandom), W'($urandom));
      end
      send(W'($urandom), W'($urandom));
      send(W'($urandom), W'($urandom));
      target = D - 1 + ((cyc - 1 - (D - 1)) / F) * F + 10 * D;
      t = 0;
      while (cyc <= target && t < 2 * F) begin
         @(posedge clk);
         t++;
      end
      #2 reset_i = 1'b0;
      #1;
      chk("midrst_sclk", 64'(sclk_o), 64'(0));
      chk("midrst_lrclk", 64'(lrclk_o), 64'(1));
      chk("midrst_sdata", 64'(sdata_o), 64'(0));
      chk("midrst_ready", 64'(ready_o), 64'(1));
      chk("midrst_underrun", 64'(underrun_o), 64'(0));
      repeat (3) @(negedge clk);
      #1 reset_i = 1'b1;
      idle(3 * F);
      send(W'($urandom), W'($urandom));
      t = 0;
      while (q.size() > 0 && t < 4 * F) begin
         @(posedge clk);
         t++;
      end
      idle(F);
      chk("drain", 64'(q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
Downstream stage of the volume block: serialises the attenuated 24-bit audio samples onto an I2S link to the DAC/codec.
- Accepts one stereo sample pair per frame via valid/ready into a one-entry holding register.
- Generates the bit clock (sclk_o) and word-select (lrclk_o) from clk_i.
- Shifts the data out MSB-first with the standard I2S one-bit delay after each word-select transition.

Parameters:
width_p, 24, sample width in bits (matches volume sound_o)
slot_width_p, 32, sclk periods per channel slot; must be >= width_p+1
sclk_div_p, 4, clk_i cycles per sclk period; even, >= 2

Ports:
clk_i  in  1  system clock
reset_i  in  1  reset, asynchronous, active-low
left_i  in  width_p  left-channel sample
right_i  in  width_p  right-channel sample
valid_i  in  1  left_i/right_i valid
ready_o  out  1  holding register empty; transfer on valid_i & ready_o at posedge clk_i
sclk_o  out  1  I2S bit clock, 50% duty
lrclk_o  out  1  word select; 0 = left slot, 1 = right slot
sdata_o  out  1  serial data; changes only on sclk falling edges
underrun_o  out  1  one-cycle pulse when a frame starts with no sample available (RUN state only)

Behaviour:
- Reset values (reset_i low, applied immediately):
  - div_r=0, bit_r=2*slot_width_p-1
  - sclk_o=0, lrclk_o=1, sdata_o=0, ready_o=1, underrun_o=0
  - holding register empty; state=IDLE
- All outputs are registered except ready_o, which equals !hold_full_r.
- Divider: div_r counts 0..sclk_div_p-1 and wraps.
  - Rise tick (div_r==sclk_div_p/2-1): sclk_o<=1.
  - Fall tick (div_r==sclk_div_p-1): sclk_o<=0.
- Each fall tick:
  - bit_r <= (bit_r==2*slot_width_p-1) ? 0 : bit_r+1
  - lrclk_o <= (next bit_r >= slot_width_p)
  - sdata_o updated for the next bit_r.
- Frame boundary: the fall tick on which bit_r wraps to 0. The first fall tick after reset release (clk cycle sclk_div_p-1) is a frame boundary.
- Slot data, per slot position p (0..slot_width_p-1):
  - p=0: sdata_o=0 (one-bit delay).
  - p=1..width_p: bit width_p-p of that channel's word, i.e. MSB first.
  - p>width_p: 0 (padding).
- Holding register:
  - Loaded on valid_i & ready_o.
  - At a frame boundary with hold_full_r=1: contents copy into shadow left/right registers and hold_full_r clears, so ready_o rises the next cycle.
  - No bypass: a sample offered on the boundary cycle while full is not accepted.
- States:
  - IDLE: shadow registers hold 0, sdata_o=0, clocks run, no underrun reported. IDLE->RUN at the first frame boundary with hold_full_r=1 (that sample is transmitted in that frame).
  - RUN: at a frame boundary with hold_full_r=0, the shadow registers load 0 (silent frame) and underrun_o=1 for exactly one clk cycle. The block stays in RUN.
- Latency: a sample accepted during frame N is transmitted in frame N+1. Left MSB is on sdata_o from the fall tick at p=1 of the left slot.
- Width arithmetic: bit_r is $clog2(2*slot_width_p) bits; div_r is $clog2(sclk_div_p) bits; no truncation of data.
- Reset mid-frame: the frame is aborted and the held sample is discarded; after release the block behaves exactly as after power-on.

Decomposition:
- Package i2s_pkg:
  - state enum (IDLE, RUN)
  - default localparams for width, slot and divider
  - function computing slot position and channel from bit_r
- Sub-module i2s_clkgen: divider producing sclk_o, rise_tick_o and fall_tick_o; parameter sclk_div_p.
- i2s_tx holds the handshake, the holding and shadow registers, the bit counter and the serialiser.

Test Plan:
- Reset: hold reset_i=0 for 10 cycles -> sclk_o=0, lrclk_o=1, sdata_o=0, ready_o=1, underrun_o=0 throughout; no sclk toggling.
- Single sample: accept left=0xA5F00F, right=0x123456 before the first frame boundary -> sampling sdata_o on sclk rises gives 0, then 101001011111000000001111, then 7 zeros with lrclk_o=0; the right slot gives 0, then 0x123456 MSB-first, then 7 zeros with lrclk_o=1.
- Underrun: no second sample -> next frame (256 clk cycles later at defaults) is all zeros and underrun_o is high for exactly 1 cycle at the boundary. No underrun_o in IDLE before the first sample.
- Streaming: valid_i held high with left=right=0x000001,0x000002,... -> ready_o low after each accept and high one cycle after each boundary; each frame carries exactly the next value; underrun_o never asserts.
- Extremes: left=0xFFFFFF, right=0x800000 -> 24 ones on left; a single 1 at right p=1; padding and p=0 bits are 0.
- Reset mid-frame: drop reset_i at left p=10 -> outputs at reset values within the same cycle; after release the state is IDLE, the held sample is discarded and the first boundary occurs 3 cycles later.
